// File: rtl/walksat_pkg.sv
// -----------------------------------------------------------------------------
// walksat_pkg
// Shared definitions for the WalkSAT run sequencer: FSM state encoding, loop
// stage indices (bit positions of stage_req_o / stage_ack_i) and load-target
// table selects (load_sel_i codes).
// -----------------------------------------------------------------------------
package walksat_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_SELECT  = 4'd2,
        ST_READ_CT = 4'd3,
        ST_READ_VT = 4'd4,
        ST_EVAL    = 4'd5,
        ST_GATHER  = 4'd6,
        ST_CHECK   = 4'd7,
        ST_RESTART = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    // Loop stage indices into the req/ack vectors
    localparam int STG_SELECT  = 0;
    localparam int STG_READ_CT = 1;
    localparam int STG_READ_VT = 2;
    localparam int STG_EVAL    = 3;
    localparam int STG_GATHER  = 4;

    // Load targets; TBL_NONE is the illegal code whose beats are dropped
    localparam logic [1:0] TBL_ATT  = 2'd0;
    localparam logic [1:0] TBL_CT   = 2'd1;
    localparam logic [1:0] TBL_UCB  = 2'd2;
    localparam logic [1:0] TBL_NONE = 2'd3;

endpackage

// File: rtl/walksat_budget_counter.sv
// -----------------------------------------------------------------------------
// walksat_budget_counter
// Flip and try counters for the WalkSAT sequencer, with saturation and budget
// compares against the live budget inputs.
//   clear_i        : clear both counters (start of a run)
//   flip_inc_i     : one more flip (saturating at all-ones)
//   flip_clr_i     : clear the flip counter only (restart of a try)
//   try_inc_i      : one more completed try (saturating)
//   max_flips_i    : flips per try, 0 = unlimited
//   max_tries_i    : tries per run, 0 behaves as 1
//   flip_count_o / try_count_o : current counts
//   flip_limit_o   : the flip about to be counted is the last of this try
//   try_limit_o    : the try about to end is the last of this run
// -----------------------------------------------------------------------------
module walksat_budget_counter #(
    parameter int FLIP_WIDTH = 32,
    parameter int TRY_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    input  logic                  flip_inc_i,
    input  logic                  flip_clr_i,
    input  logic                  try_inc_i,
    input  logic [FLIP_WIDTH-1:0] max_flips_i,
    input  logic [TRY_WIDTH-1:0]  max_tries_i,
    output logic [FLIP_WIDTH-1:0] flip_count_o,
    output logic [TRY_WIDTH-1:0]  try_count_o,
    output logic                  flip_limit_o,
    output logic                  try_limit_o
);

    logic [FLIP_WIDTH-1:0] flip_q, flip_d;
    logic [TRY_WIDTH-1:0]  try_q, try_d;
    logic [TRY_WIDTH-1:0]  eff_tries_s;

    // Budget compares: one bit wider so count+1 never wraps before comparing
    always_comb begin
        eff_tries_s  = (max_tries_i == '0) ? TRY_WIDTH'(1) : max_tries_i;
        flip_limit_o = (max_flips_i != '0) &&
                       (({1'b0, flip_q} + (FLIP_WIDTH+1)'(1)) == {1'b0, max_flips_i});
        try_limit_o  = ({1'b0, try_q} + (TRY_WIDTH+1)'(1)) >= {1'b0, eff_tries_s};
    end

    // Next-count logic with clear priority and saturation
    always_comb begin
        flip_d = flip_q;
        try_d  = try_q;
        if (clear_i) begin
            flip_d = '0;
            try_d  = '0;
        end else begin
            if (flip_clr_i) begin
                flip_d = '0;
            end else if (flip_inc_i && (flip_q != '1)) begin
                flip_d = flip_q + FLIP_WIDTH'(1);
            end else begin
                flip_d = flip_q;
            end
            if (try_inc_i && (try_q != '1)) begin
                try_d = try_q + TRY_WIDTH'(1);
            end else begin
                try_d = try_q;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_q <= '0;
            try_q  <= '0;
        end else begin
            flip_q <= flip_d;
            try_q  <= try_d;
        end
    end

    assign flip_count_o = flip_q;
    assign try_count_o  = try_q;

endmodule

// File: rtl/walksat_sequencer.sv
// -----------------------------------------------------------------------------
// walksat_sequencer
// Top-level WalkSAT run controller. Loads the tables, then repeatedly walks
// the flip loop SELECT -> READ_CT -> READ_VT -> EVAL -> GATHER -> CHECK with a
// req/ack handshake per stage, restarting tries and stopping on a satisfying
// assignment, an exhausted budget or abort.
//   start / abort              : run control
//   max_flips_i / max_tries_i  : live budgets (0 flips = unlimited, 0 tries = 1)
//   load_*                     : host load beats; load_ready_o high in LOAD
//   tbl_wr_en_o                : one-hot table write strobe (ATT, CT, UCB)
//   stage_req_o / stage_ack_i  : per-stage handshake, one-hot request
//   unsat_count_i              : unsat clause count seen in CHECK
//   restart_o                  : one-cycle re-randomise pulse
//   flip_count_o / try_count_o : status counters
//   busy_o / done_o / sat_o    : run status
// -----------------------------------------------------------------------------
module walksat_sequencer
    import walksat_pkg::*;
#(
    parameter int NUM_STAGES      = 5,
    parameter int FLIP_WIDTH      = 32,
    parameter int TRY_WIDTH       = 8,
    parameter int UCB_COUNT_WIDTH = 12,
    parameter int NUM_TABLES      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [FLIP_WIDTH-1:0]      max_flips_i,
    input  logic [TRY_WIDTH-1:0]       max_tries_i,
    input  logic                       load_valid_i,
    input  logic [1:0]                 load_sel_i,
    input  logic                       load_last_i,
    output logic                       load_ready_o,
    output logic [NUM_TABLES-1:0]      tbl_wr_en_o,
    output logic [NUM_STAGES-1:0]      stage_req_o,
    input  logic [NUM_STAGES-1:0]      stage_ack_i,
    input  logic [UCB_COUNT_WIDTH-1:0] unsat_count_i,
    output logic                       restart_o,
    output logic [FLIP_WIDTH-1:0]      flip_count_o,
    output logic [TRY_WIDTH-1:0]       try_count_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       sat_o
);

    state_e state_q, state_d;
    logic   sat_q, sat_d;
    logic   cnt_clear_s, flip_inc_s, flip_clr_s, try_inc_s;
    logic   flip_limit_s, try_limit_s;

    walksat_budget_counter #(
        .FLIP_WIDTH (FLIP_WIDTH),
        .TRY_WIDTH  (TRY_WIDTH)
    ) u_budget (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (cnt_clear_s),
        .flip_inc_i   (flip_inc_s),
        .flip_clr_i   (flip_clr_s),
        .try_inc_i    (try_inc_s),
        .max_flips_i  (max_flips_i),
        .max_tries_i  (max_tries_i),
        .flip_count_o (flip_count_o),
        .try_count_o  (try_count_o),
        .flip_limit_o (flip_limit_s),
        .try_limit_o  (try_limit_s)
    );

    // Next-state, sat flag and counter control
    always_comb begin
        state_d     = state_q;
        sat_d       = sat_q;
        cnt_clear_s = 1'b0;
        flip_inc_s  = 1'b0;
        flip_clr_s  = 1'b0;
        try_inc_s   = 1'b0;
        // abort wins over everything, including start while already in DONE
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_DONE;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_LOAD;
                        sat_d       = 1'b0;
                        cnt_clear_s = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                // last without valid is not a beat and is ignored
                ST_LOAD:    state_d = (load_valid_i && load_last_i) ? ST_SELECT : ST_LOAD;
                ST_SELECT:  state_d = stage_ack_i[STG_SELECT]  ? ST_READ_CT : ST_SELECT;
                ST_READ_CT: state_d = stage_ack_i[STG_READ_CT] ? ST_READ_VT : ST_READ_CT;
                ST_READ_VT: state_d = stage_ack_i[STG_READ_VT] ? ST_EVAL    : ST_READ_VT;
                ST_EVAL:    state_d = stage_ack_i[STG_EVAL]    ? ST_GATHER  : ST_EVAL;
                ST_GATHER:  state_d = stage_ack_i[STG_GATHER]  ? ST_CHECK   : ST_GATHER;
                ST_CHECK: begin
                    if (unsat_count_i == '0) begin
                        state_d = ST_DONE;
                        sat_d   = 1'b1;
                    end else begin
                        flip_inc_s = 1'b1;
                        if (flip_limit_s) begin
                            if (try_limit_s) begin
                                // final try: count it here since RESTART is skipped
                                state_d   = ST_DONE;
                                sat_d     = 1'b0;
                                try_inc_s = 1'b1;
                            end else begin
                                state_d = ST_RESTART;
                            end
                        end else begin
                            state_d = ST_SELECT;
                        end
                    end
                end
                ST_RESTART: begin
                    flip_clr_s = 1'b1;
                    try_inc_s  = 1'b1;
                    state_d    = ST_SELECT;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and sat registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sat_q   <= sat_d;
        end
    end

    // One-hot stage request decoded from the registered state
    always_comb begin
        stage_req_o = '0;
        case (state_q)
            ST_SELECT:  stage_req_o[STG_SELECT]  = 1'b1;
            ST_READ_CT: stage_req_o[STG_READ_CT] = 1'b1;
            ST_READ_VT: stage_req_o[STG_READ_VT] = 1'b1;
            ST_EVAL:    stage_req_o[STG_EVAL]    = 1'b1;
            ST_GATHER:  stage_req_o[STG_GATHER]  = 1'b1;
            default:    stage_req_o = '0;
        endcase
    end

    // Table write strobe follows the beat combinationally; TBL_NONE drops it
    always_comb begin
        tbl_wr_en_o = '0;
        if ((state_q == ST_LOAD) && load_valid_i && (load_sel_i != TBL_NONE)) begin
            tbl_wr_en_o = NUM_TABLES'(1) << load_sel_i;
        end else begin
            tbl_wr_en_o = '0;
        end
    end

    assign load_ready_o = (state_q == ST_LOAD);
    assign restart_o    = (state_q == ST_RESTART);
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o       = (state_q == ST_DONE);
    assign sat_o        = sat_q;

endmodule

// File: tb/tb_walksat_sequencer.sv
module tb_walksat_sequencer;

    localparam int FW = 32;
    localparam int TW = 8;
    localparam int UW = 12;
    localparam int NS = 5;
    localparam int NT = 3;

    logic          clk;
    logic          rst, start, abort;
    logic [FW-1:0] max_flips_i;
    logic [TW-1:0] max_tries_i;
    logic          load_valid_i, load_last_i, load_ready_o;
    logic [1:0]    load_sel_i;
    logic [NT-1:0] tbl_wr_en_o;
    logic [NS-1:0] stage_req_o, stage_ack_i;
    logic [UW-1:0] unsat_count_i;
    logic          restart_o, busy_o, done_o, sat_o;
    logic [FW-1:0] flip_count_o;
    logic [TW-1:0] try_count_o;

    walksat_sequencer #(
        .NUM_STAGES(NS), .FLIP_WIDTH(FW), .TRY_WIDTH(TW),
        .UCB_COUNT_WIDTH(UW), .NUM_TABLES(NT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .max_flips_i(max_flips_i), .max_tries_i(max_tries_i),
        .load_valid_i(load_valid_i), .load_sel_i(load_sel_i),
        .load_last_i(load_last_i), .load_ready_o(load_ready_o),
        .tbl_wr_en_o(tbl_wr_en_o), .stage_req_o(stage_req_o),
        .stage_ack_i(stage_ack_i), .unsat_count_i(unsat_count_i),
        .restart_o(restart_o), .flip_count_o(flip_count_o),
        .try_count_o(try_count_o), .busy_o(busy_o), .done_o(done_o),
        .sat_o(sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit sat;
        int flips;
        int tries;
        int restarts;
    } run_t;

    run_t        exp_runs[$];
    logic [2:0]  exp_wr[$];
    run_t        e_run;
    logic [2:0]  e_wr;
    int          n_checks = 0;
    int          n_fail   = 0;

    // responder control: 0 = acks tied high, 1 = random acks, 2 = bench drives
    int          mode       = 2;
    int          gather_idx = 0;
    int          sat_at     = -1;
    logic [4:0]  resp_a;
    logic        prev_done  = 1'b0;
    int          restarts_seen = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: walk the flip/try rules with plain counters
    function automatic run_t model(input int mf, input int mt, input int sat_idx);
        run_t r;
        int   eff;
        int   checks;
        r.sat = 1'b0; r.flips = 0; r.tries = 0; r.restarts = 0;
        eff = (mt == 0) ? 1 : mt;
        checks = 0;
        for (int g = 0; g < 100000; g++) begin
            if (checks == sat_idx) begin
                r.sat = 1'b1;
                return r;
            end
            checks++;
            r.flips++;
            if (mf != 0 && r.flips == mf) begin
                r.tries++;
                if (r.tries >= eff) return r;
                r.restarts++;
                r.flips = 0;
            end
        end
        return r;
    endfunction

    task automatic start_run(input int mf, input int mt);
        max_flips_i = FW'(mf);
        max_tries_i = TW'(mt);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_beat(input int sel, input bit last, input bit valid);
        logic [2:0] w;
        load_valid_i = valid;
        load_sel_i   = 2'(sel);
        load_last_i  = last;
        w = (sel < 3) ? 3'(1 << sel) : 3'b000;
        if (valid) exp_wr.push_back(w);
        tick();
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name, output int cycles);
        cycles = 0;
        while (!done_o && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!done_o) begin
            check(name, 0, 1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_sat"}, sat_o, 0);
        check({tag, "_flips"}, flip_count_o, 0);
        check({tag, "_tries"}, try_count_o, 0);
        check({tag, "_req"}, stage_req_o, 0);
        check({tag, "_restart"}, restart_o, 0);
        check({tag, "_ready"}, load_ready_o, 0);
        check({tag, "_wr"}, tbl_wr_en_o, 0);
    endtask

    // Stage responder: acks and unsat count for modes 0/1
    always @(posedge clk) begin
        #1;
        if (mode != 2) begin
            resp_a = (mode == 0) ? 5'h1f : 5'($urandom);
            stage_ack_i = resp_a;
            if (stage_req_o[4] && resp_a[4]) begin
                if (gather_idx == sat_at) unsat_count_i = 12'd0;
                else if (mode == 0) unsat_count_i = 12'd5;
                else unsat_count_i = 12'($urandom_range(1, 4095));
                gather_idx++;
            end
        end
    end

    // Monitor: pops scoreboards when the DUT presents a write or a finished run
    always @(negedge clk) begin
        if (restart_o) restarts_seen++;
        if (done_o && !prev_done) begin
            if (exp_runs.size() == 0) begin
                check("run_unexpected", 1, 0);
            end else begin
                e_run = exp_runs.pop_front();
                check("run_sat", sat_o, e_run.sat);
                check("run_flips", flip_count_o, e_run.flips);
                check("run_tries", try_count_o, e_run.tries);
                check("run_restarts", restarts_seen, e_run.restarts);
            end
            restarts_seen = 0;
        end
        prev_done = done_o;
        if (load_ready_o) begin
            if (load_valid_i) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("wr_en", tbl_wr_en_o, e_wr);
                end
            end else begin
                check("wr_idle", tbl_wr_en_o, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc;
        int sels[10];
        int mf, mt, nb;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        max_flips_i = '0; max_tries_i = '0;
        load_valid_i = 1'b0; load_sel_i = 2'd0; load_last_i = 1'b0;
        stage_ack_i = '0; unsat_count_i = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Load phase: 4 ATT, 2 CT, 3 UCB, one dropped sel=3 beat, a bubble with last
        mode = 0; gather_idx = 0; sat_at = -1;
        exp_runs.push_back(model(1, 1, -1));
        start_run(1, 1);
        sels = '{0, 1, 0, 2, 3, 0, 1, 2, 0, 2};
        for (int i = 0; i < 10; i++) begin
            if (i == 5) load_beat(0, 1'b1, 1'b0);
            load_beat(sels[i], (i == 9), 1'b1);
        end
        check("select_after_last", stage_req_o, 5'b00001);
        wait_done(200, "load_run_timeout", cyc);
        tick();

        // Two tries of three flips, acks tied high
        gather_idx = 0; sat_at = -1;
        exp_runs.push_back(model(3, 2, -1));
        start_run(3, 2);
        load_beat(0, 1'b1, 1'b1);
        wait_done(500, "budget_run_timeout", cyc);
        check("min_latency", cyc, 37);
        check("budget_sat", sat_o, 0);
        check("budget_tries", try_count_o, 2);
        check("budget_flips", flip_count_o, 3);
        tick();

        // Satisfied on the second CHECK, unlimited flips
        gather_idx = 0; sat_at = 1;
        exp_runs.push_back(model(0, 1, 1));
        start_run(0, 1);
        load_beat(2, 1'b1, 1'b1);
        wait_done(500, "sat_run_timeout", cyc);
        check("sat_flag", sat_o, 1);
        check("sat_flips", flip_count_o, 1);
        tick();

        // Stall in READ_VT with a stray ack on bit 0
        mode = 2;
        tick();
        stage_ack_i = '0;
        exp_runs.push_back(model(1, 1, -1));
        start_run(1, 1);
        load_beat(1, 1'b1, 1'b1);
        stage_ack_i = 5'b00001; tick();
        stage_ack_i = 5'b00010; tick();
        stage_ack_i = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            check("rdvt_hold", stage_req_o, 5'b00100);
            tick();
        end
        stage_ack_i = 5'b00100; tick();
        stage_ack_i = 5'b01000; tick();
        unsat_count_i = 12'd7;
        stage_ack_i = 5'b10000; tick();
        stage_ack_i = 5'b00000; tick();
        wait_done(5, "stall_run_timeout", cyc);
        tick();

        // Abort in EVAL after one completed flip
        exp_runs.push_back('{sat: 1'b0, flips: 1, tries: 0, restarts: 0});
        start_run(0, 3);
        load_beat(0, 1'b1, 1'b1);
        unsat_count_i = 12'd9;
        for (int k = 0; k < 5; k++) begin
            stage_ack_i = 5'(1 << k);
            tick();
        end
        stage_ack_i = '0;
        tick();
        check("flip_after_check", flip_count_o, 1);
        for (int k = 0; k < 3; k++) begin
            stage_ack_i = 5'(1 << k);
            tick();
        end
        stage_ack_i = '0;
        check("eval_req", stage_req_o, 5'b01000);
        abort = 1'b1;
        tick();
        check("abort_done", done_o, 1);
        check("abort_sat", sat_o, 0);
        check("abort_req", stage_req_o, 0);
        start = 1'b1;
        tick();
        check("abort_beats_start", done_o, 1);
        abort = 1'b0;
        start = 1'b0;
        start_run(1, 1);
        check("restart_ready", load_ready_o, 1);
        check("restart_flips", flip_count_o, 0);
        check("restart_tries", try_count_o, 0);
        check("restart_busy", busy_o, 1);

        // Reset in GATHER
        load_beat(1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            stage_ack_i = 5'(1 << k);
            tick();
        end
        stage_ack_i = '0;
        check("gather_req", stage_req_o, 5'b10000);
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        tick();

        // Randomised runs with random stalls and stray acks
        mode = 1;
        tick();
        for (int r = 0; r < 25; r++) begin
            mf = $urandom_range(0, 4);
            mt = $urandom_range(0, 3);
            if (mf == 0) sat_at = $urandom_range(0, 6);
            else sat_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10) : -1;
            gather_idx = 0;
            exp_runs.push_back(model(mf, mt, sat_at));
            start_run(mf, mt);
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) load_beat(0, 1'b1, 1'b0);
                load_beat($urandom_range(0, 3), (b == nb - 1), 1'b1);
            end
            wait_done(3000, "rand_run_timeout", cyc);
            tick();
        end

        repeat (3) tick();
        check("runs_pending", exp_runs.size(), 0);
        check("wr_pending", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/walksat_sequencer.md
Name: walksat_sequencer

Overview:
Parametrised successor to the WalkSAT top-level controller. Sequences the table-load phase, then the flip loop (select unsat clause, read clause table, read variable table, evaluate, gather unsat, check), with per-stage req/ack handshakes instead of fixed timing. Adds runtime flip/try budgets, restarts, abort, and status counters. Sits between the host load interface and the ATT/CT/UCB datapath stages.

Parameters:
NUM_STAGES, 5, loop stages with handshakes: 0 SELECT, 1 READ_CT, 2 READ_VT, 3 EVAL, 4 GATHER
FLIP_WIDTH, 32, width of the flip counter and flip budget
TRY_WIDTH, 8, width of the try counter and try budget
UCB_COUNT_WIDTH, 12, width of the unsat-buffer occupancy input
NUM_TABLES, 3, load targets: 0 ATT, 1 CT, 2 UCB

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a run (sampled in IDLE/DONE only)
abort  in  1  force DONE from any non-IDLE state
max_flips_i  in  FLIP_WIDTH  flips per try; 0 means unlimited
max_tries_i  in  TRY_WIDTH  tries per run; 0 is treated as 1
load_valid_i  in  1  load beat valid
load_sel_i  in  2  target table of the beat
load_last_i  in  1  final load beat
load_ready_o  out  1  high in LOAD
tbl_wr_en_o  out  NUM_TABLES  one-hot write enable (valid & ready & legal sel)
stage_req_o  out  NUM_STAGES  one-hot request to the active stage
stage_ack_i  in  NUM_STAGES  stage completion
unsat_count_i  in  UCB_COUNT_WIDTH  unsat clauses after GATHER
restart_o  out  1  one-cycle pulse: datapath re-randomises assignment
flip_count_o  out  FLIP_WIDTH  flips in the current try
try_count_o  out  TRY_WIDTH  completed tries
busy_o  out  1  state not IDLE/DONE
done_o  out  1  high in DONE
sat_o  out  1  valid with done_o; 1 = satisfying assignment found

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, LOAD, SELECT, READ_CT, READ_VT, EVAL, GATHER, CHECK, RESTART, DONE.
- IDLE/DONE + start: flip and try counters cleared, sat_o cleared, go to LOAD next cycle.
- LOAD: load_ready_o=1; tbl_wr_en_o combinational from load_valid_i and load_sel_i; load_sel_i=3 drops the beat with no write. Beat with load_last_i goes to SELECT; load_last_i without load_valid_i is ignored.
- Stage states: stage_req_o bit k held high while in stage k. The cycle stage_ack_i[k] is seen, advance to the next stage (GATHER goes to CHECK). Acks on other bits are ignored. No timeout.
- CHECK, one cycle, evaluated in priority order:
  1. unsat_count_i==0: go to DONE, sat_o=1.
  2. Otherwise flip_count += 1. If max_flips_i!=0 and flip_count+1 == max_flips_i, the try ends.
  3. Try end: if try_count+1 >= max(max_tries_i,1), go to DONE, sat_o=0, try_count += 1. Otherwise go to RESTART.
  4. Else go to SELECT.
- RESTART: restart_o=1 for exactly one cycle; flip_count=0; try_count += 1; then SELECT.
- Flip counter saturates at all-ones when unlimited; no wrap.
- abort in any state except IDLE: next state DONE, sat_o=0, stage_req_o dropped next cycle. abort beats start in DONE.
- Budgets are sampled live, not latched.
- Minimum loop latency: 6 cycles per flip (5 stages with same-cycle ack, plus CHECK).

Decomposition:
- Package walksat_pkg: state encoding, stage index constants (STG_SELECT..STG_GATHER), table select constants (TBL_ATT/CT/UCB).
- Optional sub-module walksat_budget_counter: flip/try counters with saturate, compare and clear.
- The FSM stays in walksat_sequencer.

Test Plan:
- Load 4 ATT, 2 CT, 3 UCB beats, last on beat 9: tbl_wr_en_o one-hot matches each sel; sel=3 beat gives no write; SELECT entered the cycle after last.
- max_flips_i=3, max_tries_i=2, unsat_count_i=5 always, acks tied high: one restart_o pulse after flip 3; DONE with sat_o=0, try_count_o=2, flip_count_o=3.
- unsat_count_i=0 on the second CHECK: DONE, sat_o=1, flip_count_o=1, no restart_o.
- Ack held low in READ_VT for 10 cycles: stage_req_o=5'b00100 held stable; stray ack on bit 0 ignored.
- abort asserted in EVAL: DONE next cycle, sat_o=0, stage_req_o=0; start afterwards re-enters LOAD with counters cleared.
- rst asserted mid-GATHER: next cycle IDLE, all outputs 0.
